voice_phase_bank: RTL and testbench
===================================

Name: voice_phase_bank

Overview:
Per-voice phase accumulator bank for the polyphonic synth. It holds a 32-bit phase and a phase increment for each of 8 voices, and accepts note-on/note-off key events through a valid/ready handshake. Once per sample tick it advances all gated phases, using a single time-multiplexed adder to meet timing. Its phase_out and gate_out feed the wavetable address generator directly.

Parameters:
NUM_VOICES, 8, number of voices; fixed at 8 by the downstream address generator.
PHASE_WIDTH, 32, phase accumulator and increment width in bits.
IDX_WIDTH, $clog2(NUM_VOICES) = 3, voice index width.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
sample_tick_in  input  1  one-cycle strobe at the audio sample rate
key_valid_in  input  1  key event valid
key_ready_out  output  1  key event accepted when high together with key_valid_in
key_on_in  input  1  1 = note-on, 0 = note-off
key_voice_in  input  IDX_WIDTH  target voice
key_incr_in  input  PHASE_WIDTH  phase increment; used on note-on only
overrun_clear_in  input  1  clears overrun_out
phase_out  output  PHASE_WIDTH x NUM_VOICES  unpacked array, one current phase per voice
gate_out  output  NUM_VOICES  gate bit per voice
phase_valid_out  output  1  one-cycle pulse; all phases updated for this sample
overrun_out  output  1  sticky; a tick arrived while a sweep was in progress

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in. While rst_n_in is low, with no clock edge needed:
  - all phases, increments and gates are 0;
  - state = IDLE, sweep index = 0;
  - phase_valid_out = 0, overrun_out = 0.
  - Key events are ignored while in reset.
- Reset mid-sweep aborts the sweep. There is no partial update after release.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when sample_tick_in is high; index <= 0.
  - SWEEP: in the cycle with index k, phase[k] <= phase[k] + incr[k] if gate[k] is set, else phase[k] is held. Index increments each cycle. At index NUM_VOICES-1, go to DONE.
  - DONE: phase_valid_out = 1 for exactly this cycle; then -> IDLE.
- Latency: a tick sampled in cycle t gives SWEEP in cycles t+1..t+8. phase_out[k] changes from cycle t+2+k. phase_valid_out is high in cycle t+9 only.
- Arithmetic: unsigned addition modulo 2^PHASE_WIDTH; carry out is discarded (wrap-around is intended).
- key_ready_out = (state == IDLE), combinational. An event is accepted on a clock edge where key_valid_in and key_ready_out are both high. Its effect is visible the next cycle.
  - Note-on: incr[v] <= key_incr_in, gate[v] <= 1, phase[v] <= 0 (retrigger, even if the voice is already on).
  - Note-off: gate[v] <= 0, phase[v] <= 0. incr[v] is unchanged. Note-off on an idle voice is harmless.
  - Note-on with increment 0: gate = 1 and the phase stays 0.
- Simultaneous key accept and tick in IDLE: the key is applied at that edge and the sweep starts next cycle, so the sweep uses the new values.
- Tick in SWEEP or DONE: the tick is dropped and overrun_out <= 1 next cycle. It stays set until overrun_clear_in is high. If set and clear occur in the same cycle, set wins.
- Outputs are registered; phase_out and gate_out reflect register state directly.

Decomposition:
- Shared package synth_pkg holds:
  - NUM_VOICES, PHASE_WIDTH, IDX_WIDTH;
  - phase_t (logic [PHASE_WIDTH-1:0]) and voice_idx_t;
  - typedef enum bank_state_t {IDLE, SWEEP, DONE}.
- The address generator imports the same constants.
- No sub-module. The single shared adder and the index mux stay inline; the block is small enough to stay flat.

Test Plan:
1. Reset, then note-on voice 2 with incr 0x0100_0000, then 3 ticks spaced 20 cycles apart -> phase_out[2] = 0x0300_0000, all other phases 0, gate_out = 8'b0000_0100, three phase_valid_out pulses.
2. Note-on voice 0 with incr 0x8000_0000, then 3 ticks -> phase_out[0] goes 0x8000_0000, 0x0000_0000, 0x8000_0000 (wrap).
3. All 8 voices on with incr = voice+1; tick at cycle t -> phase_out[k] updates exactly at t+2+k; phase_valid_out is high only in t+9; key_ready_out is low during t+1..t+9.
4. Second tick at t+4 during a sweep -> overrun_out = 1 from t+5, only one phase_valid_out pulse; overrun_clear_in pulse -> 0; clear and tick-in-sweep in the same cycle -> remains 1.
5. key_valid_in held high (note-off voice 2) starting at t+3 during a sweep -> accepted at the t+10 edge; gate_out[2] = 0 and phase_out[2] = 0 at t+11; tick plus key in the same IDLE cycle -> key applied before the sweep.
6. rst_n_in driven low at t+5 mid-sweep, between clock edges -> all outputs 0 immediately; after release, key_ready_out = 1 and no phase_valid_out pulse occurs.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice datapath.
// The address generator imports the same package.
package synth_pkg;

  localparam int NUM_VOICES  = 8;
  localparam int PHASE_WIDTH = 32;
  localparam int IDX_WIDTH   = $clog2(NUM_VOICES);

  typedef logic [PHASE_WIDTH-1:0] phase_t;
  typedef logic [IDX_WIDTH-1:0]   voice_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } bank_state_t;

endpackage

// File: rtl/voice_phase_bank.sv
// Eight-voice phase accumulator bank. Each sample tick sweeps the voices one
// per cycle through a single shared adder. Key events are taken only while idle.
module voice_phase_bank
  import synth_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   sample_tick_in,
  input  logic                   key_valid_in,
  output logic                   key_ready_out,
  input  logic                   key_on_in,
  input  logic [IDX_WIDTH-1:0]   key_voice_in,
  input  logic [PHASE_WIDTH-1:0] key_incr_in,
  input  logic                   overrun_clear_in,
  output logic [PHASE_WIDTH-1:0] phase_out [NUM_VOICES],
  output logic [NUM_VOICES-1:0]  gate_out,
  output logic                   phase_valid_out,
  output logic                   overrun_out
);

  bank_state_t            state_r;
  voice_idx_t             idx_r;
  phase_t                 phase_r [NUM_VOICES];
  phase_t                 incr_r  [NUM_VOICES];
  logic [NUM_VOICES-1:0]  gate_r;
  logic                   valid_r;
  logic                   overrun_r;
  phase_t                 sum_s;
  logic                   key_accept_s;

  // Shared adder and voice mux; the carry out is dropped so phases wrap.
  always_comb begin
    sum_s        = phase_r[idx_r] + incr_r[idx_r];
    key_accept_s = 1'b0;
    if (state_r == IDLE) begin
      key_accept_s = key_valid_in;
    end else begin
      key_accept_s = 1'b0;
    end
  end

  // Sweep sequencer together with its valid pulse and sticky overrun flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (sample_tick_in && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else if (overrun_clear_in) begin
        overrun_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (sample_tick_in) begin
            state_r <= SWEEP;
            idx_r   <= '0;
          end
        end
        SWEEP: begin
          if (idx_r == voice_idx_t'(NUM_VOICES - 1)) begin
            state_r <= DONE;
            idx_r   <= '0;
            valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + voice_idx_t'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  // Per-voice state: key events write while idle, the sweep writes one voice per cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_r[i] <= '0;
        incr_r[i]  <= '0;
      end
      gate_r <= '0;
    end else if (key_accept_s) begin
      if (key_on_in) begin
        incr_r[key_voice_in] <= key_incr_in;
        gate_r[key_voice_in] <= 1'b1;
      end else begin
        gate_r[key_voice_in] <= 1'b0;
      end
      phase_r[key_voice_in] <= '0;
    end else if ((state_r == SWEEP) && gate_r[idx_r]) begin
      phase_r[idx_r] <= sum_s;
    end
  end

  assign key_ready_out   = (state_r == IDLE);
  assign phase_out       = phase_r;
  assign gate_out        = gate_r;
  assign phase_valid_out = valid_r;
  assign overrun_out     = overrun_r;

endmodule

// File: tb/tb_voice_phase_bank.sv
// Scoreboard bench for voice_phase_bank: a voice-level model predicts each sweep
// result, and a negedge monitor compares the DUT against it.
module tb_voice_phase_bank;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        key_valid;
  logic        key_ready;
  logic        key_on;
  logic [2:0]  key_voice;
  logic [31:0] key_incr;
  logic        ovr_clr;
  logic [31:0] phase_out [8];
  logic [7:0]  gate_out;
  logic        phase_valid;
  logic        overrun;

  always #5 clk = ~clk;

  voice_phase_bank dut (
    .clk_in(clk), .rst_n_in(rst_n), .sample_tick_in(tick),
    .key_valid_in(key_valid), .key_ready_out(key_ready), .key_on_in(key_on),
    .key_voice_in(key_voice), .key_incr_in(key_incr), .overrun_clear_in(ovr_clr),
    .phase_out(phase_out), .gate_out(gate_out), .phase_valid_out(phase_valid),
    .overrun_out(overrun)
  );

  int checks = 0;
  int errors = 0;

  // Model: current phases, the before/after snapshots of a sweep, and the
  // number of non-idle cycles left (a sweep occupies 9 cycles after the tick).
  logic [31:0]  m_ph [8];
  logic [31:0]  m_old [8];
  logic [31:0]  m_incr [8];
  logic [7:0]   m_gate;
  logic         m_ovr;
  int           busy;
  bit           m_acc;
  logic [263:0] sbq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [263:0] pack_dut();
    logic [263:0] p;
    for (int k = 0; k < 8; k++) p[32*k +: 32] = phase_out[k];
    p[263:256] = gate_out;
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_ph[k] = 32'd0; m_old[k] = 32'd0; m_incr[k] = 32'd0;
    end
    m_gate = 8'd0; m_ovr = 1'b0; busy = 0;
    sbq.delete();
  endtask

  // Applies one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    logic [263:0] snap;
    m_acc = 1'b0;
    if (busy != 0) begin
      if (tick) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      busy--;
    end else begin
      if (ovr_clr) m_ovr = 1'b0;
      if (key_valid) begin
        m_acc = 1'b1;
        if (key_on) begin
          m_incr[key_voice] = key_incr;
          m_gate[key_voice] = 1'b1;
        end else begin
          m_gate[key_voice] = 1'b0;
        end
        m_ph[key_voice] = 32'd0;
      end
      if (tick) begin
        for (int k = 0; k < 8; k++) begin
          m_old[k] = m_ph[k];
          if (m_gate[k]) m_ph[k] = m_ph[k] + m_incr[k];
          snap[32*k +: 32] = m_ph[k];
        end
        snap[263:256] = m_gate;
        sbq.push_back(snap);
        busy = 9;
      end
    end
  endtask

  task automatic step(input bit t, input bit kv, input bit kon, input int v,
                      input logic [31:0] inc, input bit clr);
    tick = t; key_valid = kv; key_on = kon; key_voice = v[2:0];
    key_incr = inc; ovr_clr = clr;
    @(posedge clk);
    model_edge();
    #2;
    tick = 1'b0; key_valid = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, phase_valid}, 32'd0);
    chk({nm, "_ovr"}, {31'd0, overrun}, 32'd0);
    chk({nm, "_gate"}, {24'd0, gate_out}, 32'd0);
    chk({nm, "_ready"}, {31'd0, key_ready}, 32'd1);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_ph%0d", nm, k), phase_out[k], 32'd0);
  endtask

  // Monitor: cycle-level expectations plus scoreboard pop on each valid pulse.
  always @(negedge clk) begin
    int c;
    logic [31:0] e;
    logic [263:0] exp_snap;
    c = 10 - busy;
    chk("key_ready", {31'd0, key_ready}, {31'd0, busy == 0});
    chk("phase_valid", {31'd0, phase_valid}, {31'd0, busy == 1});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("gate", {24'd0, gate_out}, {24'd0, m_gate});
    for (int k = 0; k < 8; k++) begin
      e = (busy != 0 && c < 2 + k) ? m_old[k] : m_ph[k];
      chk($sformatf("phase%0d_c%0d", k, c), phase_out[k], e);
    end
    if (phase_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_snap = sbq.pop_front();
        checks++;
        if (pack_dut() !== exp_snap) begin
          errors++;
          $display("FAIL sb_snapshot actual=%h expected=%h", pack_dut(), exp_snap);
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] wrap_exp [3];
    wrap_exp[0] = 32'h8000_0000; wrap_exp[1] = 32'h0000_0000; wrap_exp[2] = 32'h8000_0000;
    rst_n = 1'b0; tick = 1'b0; key_valid = 1'b0; key_on = 1'b0;
    key_voice = 3'd0; key_incr = 32'd0; ovr_clr = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    // Single voice, three ticks.
    step(1'b0, 1'b1, 1'b1, 2, 32'h0100_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
      idle(19);
    end
    chk("t1_phase2", phase_out[2], 32'h0300_0000);
    chk("t1_gate", {24'd0, gate_out}, 32'h0000_0004);

    // Wrap-around on voice 0.
    step(1'b0, 1'b1, 1'b1, 0, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
      idle(11);
      chk($sformatf("t2_wrap%0d", i), phase_out[0], wrap_exp[i]);
    end

    // All voices on; the monitor checks per-voice update timing.
    for (int v = 0; v < 8; v++) step(1'b0, 1'b1, 1'b1, v, 32'(v + 1), 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(12);

    // Overrun: tick at t+4, clear, then clear together with a tick mid-sweep.
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    chk("t4_ovr_set", {31'd0, overrun}, 32'd1);
    idle(8);
    step(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    chk("t4_ovr_clr", {31'd0, overrun}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    chk("t4_set_wins", {31'd0, overrun}, 32'd1);
    idle(10);
    step(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1);

    // Key held through a sweep is accepted only once the bank is idle again.
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(2);
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, 2, 32'd0, 1'b0);
      n++;
    end while (!m_acc && n < 20);
    chk("t5_accept_cycle", 32'(n), 32'd8);
    chk("t5_gate2", {31'd0, gate_out[2]}, 32'd0);
    chk("t5_phase2", phase_out[2], 32'd0);
    step(1'b1, 1'b1, 1'b1, 5, 32'h1234_5678, 1'b0);
    idle(11);
    chk("t5_phase5", phase_out[5], 32'h1234_5678);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 16) == 0, ($urandom % 4) == 0, $urandom % 2 == 1,
           int'($urandom % 8), $urandom, ($urandom % 8) == 0);
    end
    idle(12);

    // Reset mid-sweep, asserted between edges.
    step(1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    idle(4);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("t6_async");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    idle(12);
    chk("t6_ready", {31'd0, key_ready}, 32'd1);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
